// File: rtl/fifo_param_if.sv
// Producer/consumer bundle for fifo_param: write/read handshake, data and status flags.
// The FIFO owns the slave side; whoever drives push/pop/data_in uses master.
interface fifo_param_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic [CW-1:0]    count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             almost_full;
  logic             almost_empty;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, pop, data_in,
    input  data_out, count, fifo_full, fifo_empty, almost_full, almost_empty,
           overflow, underflow
  );

  modport slave (
    input  push, pop, data_in,
    output data_out, count, fifo_full, fifo_empty, almost_full, almost_empty,
           overflow, underflow
  );
endinterface

// File: rtl/fifo_param.sv
// Parametrised circular-buffer FIFO with occupancy count, threshold flags and error pulses.
// FIFO_FWFT_EN selects first-word fall-through output; default is a registered 1-cycle read.
module fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic          clk,
  input  logic          reset,
  fifo_param_if.slave   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             push_ok, pop_ok;
  logic             full, empty;

  // Status is decoded from registered count only, so no path from push/pop.
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  always_comb begin
    push_ok     = bus.push & (~full | bus.pop);
    pop_ok      = bus.pop & ~empty;
    wr_ptr_d    = wr_ptr_q + PW'(push_ok);
    rd_ptr_d    = rd_ptr_q + PW'(pop_ok);
    count_d     = count_q;
    if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
    else if (pop_ok && !push_ok) count_d = count_q - CW'(1);
    overflow_d  = bus.push & ~push_ok;
    underflow_d = bus.pop & ~pop_ok;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is never cleared; a reset only forgets it by zeroing the pointers.
  always_ff @(posedge clk) begin
    if (push_ok && !reset) mem_q[wr_ptr_q] <= bus.data_in;
  end

`ifdef FIFO_FWFT_EN
  assign bus.data_out = empty ? '0 : mem_q[rd_ptr_q];
`else
  logic [WIDTH-1:0] data_out_q, data_out_d;

  // Holds on idle cycles and on a rejected pop.
  always_comb begin
    data_out_d = data_out_q;
    if (pop_ok) data_out_d = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (reset) data_out_q <= '0;
    else       data_out_q <= data_out_d;
  end

  assign bus.data_out = data_out_q;
`endif

  assign bus.count        = count_q;
  assign bus.fifo_full    = full;
  assign bus.fifo_empty   = empty;
  assign bus.almost_full  = (count_q >= CW'(AF_LEVEL));
  assign bus.almost_empty = (count_q <= CW'(AE_LEVEL));
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param (WIDTH=8, DEPTH=4, AF=3, AE=1): directed scenarios plus
// random traffic against a queue-based reference; honours FIFO_FWFT_EN for read timing.
module tb_fifo_param;
  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  fifo_param_if #(.WIDTH(8), .DEPTH(4)) bus ();

  fifo_param #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: queue holds contents; data_out/error pulses kept as expected registers.
  logic [7:0] q [$];
  logic [7:0] m_dout;
  logic       m_ovf, m_udf;

  // One clock cycle of stimulus; rd returns the word the consumer sees for this pop.
  task automatic cyc(input logic r, input logic p, input logic o, input logic [7:0] d,
                     output logic [7:0] rd);
    bit         pok, ook;
    logic [7:0] w;
    reset = r; bus.push = p; bus.pop = o; bus.data_in = d;
    rd = 8'hxx;
`ifdef FIFO_FWFT_EN
    rd = bus.data_out;
`endif
    if (r) begin
      q.delete(); m_ovf = 1'b0; m_udf = 1'b0; m_dout = 8'h00;
    end else begin
      pok = p && (q.size() < 4 || o);
      ook = o && (q.size() > 0);
      if (ook) begin
        w = q.pop_front();
`ifndef FIFO_FWFT_EN
        m_dout = w;
`endif
      end
      if (pok) q.push_back(d);
      m_ovf = p && !pok;
      m_udf = o && !ook;
    end
`ifdef FIFO_FWFT_EN
    m_dout = (q.size() > 0) ? q[0] : 8'h00;
`endif
    @(posedge clk); #1;
`ifndef FIFO_FWFT_EN
    rd = bus.data_out;
`endif
    reset = 1'b0; bus.push = 1'b0; bus.pop = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] rd;
    cyc(1'b0, 1'b0, 1'b0, 8'h00, rd);
    n_chk++;
    if ({bus.count, bus.fifo_empty, bus.almost_empty, bus.fifo_full, bus.almost_full,
         bus.overflow, bus.underflow, bus.data_out} !== {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_state: cnt=%0d emp=%b ae=%b full=%b af=%b ovf=%b udf=%b dout=%h, want 0 1 1 0 0 0 0 00",
               bus.count, bus.fifo_empty, bus.almost_empty, bus.fifo_full, bus.almost_full,
               bus.overflow, bus.underflow, bus.data_out);
    end
  endtask

  task automatic test_fill_drain();
    logic [7:0] rd;
    logic [7:0] w [4];
    w = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 1'b0, w[i], rd);
      n_chk++;
      if ({bus.count, bus.almost_full, bus.fifo_full, bus.fifo_empty} !==
          {3'(i + 1), 1'(i >= 2), 1'(i == 3), 1'b0}) begin
        n_fail++;
        $display("FAIL fill_%0d: cnt=%0d af=%b full=%b emp=%b, want cnt=%0d af=%b full=%b emp=0",
                 i, bus.count, bus.almost_full, bus.fifo_full, bus.fifo_empty, i + 1, i >= 2, i == 3);
      end
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 8'h00, rd);
      n_chk++;
      if (rd !== w[i] || bus.count !== 3'(3 - i)) begin
        n_fail++;
        $display("FAIL drain_%0d: rd=%h cnt=%0d, want rd=%h cnt=%0d", i, rd, bus.count, w[i], 3 - i);
      end
    end
    n_chk++;
    if (bus.fifo_empty !== 1'b1 || bus.almost_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_empty: emp=%b ae=%b, want 1 1", bus.fifo_empty, bus.almost_empty);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] rd;
    logic [7:0] exp [5];
    exp = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h66};
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, exp[i], rd);
    cyc(1'b0, 1'b1, 1'b0, 8'h55, rd);
    n_chk++;
    if (bus.overflow !== 1'b1 || bus.count !== 3'd4 || bus.fifo_full !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_pulse: ovf=%b cnt=%0d full=%b, want 1 4 1", bus.overflow, bus.count, bus.fifo_full);
    end
    cyc(1'b0, 1'b0, 1'b0, 8'h00, rd);
    n_chk++;
    if (bus.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_one_cycle: ovf=%b, want 0", bus.overflow);
    end
    cyc(1'b0, 1'b1, 1'b1, 8'h66, rd);
    n_chk++;
    if (bus.overflow !== 1'b0 || bus.count !== 3'd4 || rd !== exp[0]) begin
      n_fail++;
      $display("FAIL full_push_pop: ovf=%b cnt=%0d rd=%h, want 0 4 %h", bus.overflow, bus.count, rd, exp[0]);
    end
    for (int i = 1; i < 5; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 8'h00, rd);
      n_chk++;
      if (rd !== exp[i]) begin
        n_fail++;
        $display("FAIL ovf_read_%0d: rd=%h, want %h", i, rd, exp[i]);
      end
    end
  endtask

  task automatic test_underflow();
    logic [7:0] rd;
`ifdef FIFO_FWFT_EN
    logic [7:0] hold = 8'h00;
`else
    logic [7:0] hold = 8'h66;
`endif
    cyc(1'b0, 1'b0, 1'b1, 8'h00, rd);
    n_chk++;
    if (bus.underflow !== 1'b1 || bus.count !== 3'd0 || bus.data_out !== hold) begin
      n_fail++;
      $display("FAIL udf_pulse: udf=%b cnt=%0d dout=%h, want 1 0 %h", bus.underflow, bus.count, bus.data_out, hold);
    end
    cyc(1'b0, 1'b0, 1'b0, 8'h00, rd);
    n_chk++;
    if (bus.underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL udf_one_cycle: udf=%b, want 0", bus.underflow);
    end
    cyc(1'b0, 1'b1, 1'b1, 8'hA5, rd);
    n_chk++;
    if (bus.underflow !== 1'b1 || bus.count !== 3'd1 || bus.fifo_empty !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_push_pop: udf=%b cnt=%0d emp=%b, want 1 1 0", bus.underflow, bus.count, bus.fifo_empty);
    end
    cyc(1'b0, 1'b0, 1'b1, 8'h00, rd);
    n_chk++;
    if (rd !== 8'hA5 || bus.count !== 3'd0 || bus.underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL udf_read: rd=%h cnt=%0d udf=%b, want a5 0 0", rd, bus.count, bus.underflow);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd;
    cyc(1'b0, 1'b1, 1'b0, 8'h00, rd);
    cyc(1'b0, 1'b1, 1'b0, 8'h01, rd);
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 1'b1, 1'b1, 8'(k + 2), rd);
      n_chk++;
      if (bus.count !== 3'd2 || rd !== 8'(k) || bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_%0d: cnt=%0d rd=%h ovf=%b udf=%b, want 2 %h 0 0",
                 k, bus.count, rd, bus.overflow, bus.underflow, 8'(k));
      end
    end
    for (int k = 10; k < 12; k++) begin
      cyc(1'b0, 1'b0, 1'b1, 8'h00, rd);
      n_chk++;
      if (rd !== 8'(k)) begin
        n_fail++;
        $display("FAIL b2b_drain_%0d: rd=%h, want %h", k, rd, 8'(k));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] rd;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 8'(8'h70 + i), rd);
    cyc(1'b1, 1'b1, 1'b0, 8'h77, rd);
    n_chk++;
    if (bus.count !== 3'd0 || bus.fifo_empty !== 1'b1 || bus.data_out !== 8'h00 || bus.almost_full !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: cnt=%0d emp=%b dout=%h af=%b, want 0 1 00 0",
               bus.count, bus.fifo_empty, bus.data_out, bus.almost_full);
    end
    cyc(1'b0, 1'b0, 1'b1, 8'h00, rd);
    n_chk++;
    if (bus.underflow !== 1'b1 || bus.count !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_push_ignored: udf=%b cnt=%0d, want 1 0", bus.underflow, bus.count);
    end
  endtask

  task automatic test_random();
    logic [7:0]  rd;
    logic [16:0] act, exp;
    int          n;
    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 99) < 55),
          1'($urandom_range(0, 99) < 50), 8'($urandom), rd);
      n   = q.size();
      act = {bus.count, bus.fifo_full, bus.fifo_empty, bus.almost_full, bus.almost_empty,
             bus.overflow, bus.underflow, bus.data_out};
      exp = {3'(n), 1'(n == 4), 1'(n == 0), 1'(n >= 3), 1'(n <= 1), m_ovf, m_udf, m_dout};
      n_chk++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL random_%0d: {cnt,full,emp,af,ae,ovf,udf,dout}=%h, want %h", i, act, exp);
      end
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    reset = 1'b1; bus.push = 1'b0; bus.pop = 1'b0; bus.data_in = 8'h00;
    q.delete(); m_dout = 8'h00; m_ovf = 1'b0; m_udf = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
